// File: rtl/if_id_stage_register.sv
// IF/ID pipeline register: captures fetch outputs with stall/flush/squash control,
// reports branch/jump delay-slot status back to fetch, and counts stall/flush cycles.
module if_id_stage_register #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          IF_PC,
    input  logic [31:0]          IF_PC4,
    input  logic [31:0]          IF_Inst,
    input  logic                 IF_exception,
    input  logic [31:0]          IF_EPC,
    input  logic [4:0]           IF_ExcCode,
    input  logic                 IF_BD,
    input  logic                 stall,
    input  logic                 handle_exception,
    output logic [31:0]          ID_PC,
    output logic [31:0]          ID_PC4,
    output logic [31:0]          ID_Inst,
    output logic                 ID_exception,
    output logic [31:0]          ID_EPC,
    output logic [4:0]           ID_ExcCode,
    output logic                 ID_BD,
    output logic                 ID_valid,
    output logic                 delay_slot,
    output logic [31:0]          last_PC,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    logic [31:0]          r_pc;
    logic [31:0]          r_pc4;
    logic [31:0]          r_inst;
    logic                 r_exception;
    logic [31:0]          r_epc;
    logic [4:0]           r_exccode;
    logic                 r_bd;
    logic                 r_valid;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    logic [5:0] w_op;
    logic [4:0] w_rt;
    logic [5:0] w_funct;
    logic       w_is_branch;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_pc4       <= RESET_PC + 32'd4;
            r_inst      <= '0;
            r_exception <= 1'b0;
            r_epc       <= '0;
            r_exccode   <= '0;
            r_bd        <= 1'b0;
            r_valid     <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (handle_exception) begin
            // Bubble keeps the incoming PC so last_PC still tracks fetch.
            r_pc        <= IF_PC;
            r_pc4       <= IF_PC4;
            r_inst      <= '0;
            r_exception <= 1'b0;
            r_epc       <= '0;
            r_exccode   <= '0;
            r_bd        <= 1'b0;
            r_valid     <= 1'b0;
            if (r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
        end else if (stall) begin
            if (r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
        end else begin
            r_pc        <= IF_PC;
            r_pc4       <= IF_PC4;
            r_inst      <= IF_exception ? '0 : IF_Inst;
            r_exception <= IF_exception;
            r_epc       <= IF_EPC;
            r_exccode   <= IF_ExcCode;
            r_bd        <= IF_BD;
            r_valid     <= 1'b1;
        end
    end

    always_comb begin
        w_op        = r_inst[31:26];
        w_rt        = r_inst[20:16];
        w_funct     = r_inst[5:0];
        w_is_branch = 1'b0;
        case (w_op)
            6'b000100, 6'b000101, 6'b000110, 6'b000111,
            6'b000010, 6'b000011: w_is_branch = 1'b1;
            6'b000001: w_is_branch = (w_rt == 5'b00000) || (w_rt == 5'b00001) ||
                                     (w_rt == 5'b10000) || (w_rt == 5'b10001);
            6'b000000: w_is_branch = (w_funct == 6'b001000) || (w_funct == 6'b001001);
            default:   w_is_branch = 1'b0;
        endcase
    end

    assign ID_PC        = r_pc;
    assign ID_PC4       = r_pc4;
    assign ID_Inst      = r_inst;
    assign ID_exception = r_exception;
    assign ID_EPC       = r_epc;
    assign ID_ExcCode   = r_exccode;
    assign ID_BD        = r_bd;
    assign ID_valid     = r_valid;
    assign delay_slot   = r_valid & ~r_exception & w_is_branch;
    assign last_PC      = r_pc;
    assign stall_count  = r_stall_cnt;
    assign flush_count  = r_flush_cnt;

endmodule

// File: tb/tb_if_id_stage_register.sv
// Scoreboard bench for if_id_stage_register: driver pushes model predictions,
// monitor pops and compares one cycle later. A second instance uses 4-bit counters.
module tb_if_id_stage_register;

    logic        clk = 1'b0;
    logic        reset, IF_exception, IF_BD, stall, handle_exception;
    logic [31:0] IF_PC, IF_PC4, IF_Inst, IF_EPC;
    logic [4:0]  IF_ExcCode;

    logic [31:0] ID_PC, ID_PC4, ID_Inst, ID_EPC, last_PC;
    logic        ID_exception, ID_BD, ID_valid, delay_slot;
    logic [4:0]  ID_ExcCode;
    logic [15:0] stall_count, flush_count;

    logic [31:0] s_PC, s_PC4, s_Inst, s_EPC, s_last_PC;
    logic        s_exception, s_BD, s_valid, s_delay_slot;
    logic [4:0]  s_ExcCode;
    logic [3:0]  s_stall_count, s_flush_count;

    always #5 clk = ~clk;

    if_id_stage_register #(.RESET_PC(32'h0000_3000), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .IF_PC(IF_PC), .IF_PC4(IF_PC4), .IF_Inst(IF_Inst),
        .IF_exception(IF_exception), .IF_EPC(IF_EPC), .IF_ExcCode(IF_ExcCode), .IF_BD(IF_BD),
        .stall(stall), .handle_exception(handle_exception),
        .ID_PC(ID_PC), .ID_PC4(ID_PC4), .ID_Inst(ID_Inst), .ID_exception(ID_exception),
        .ID_EPC(ID_EPC), .ID_ExcCode(ID_ExcCode), .ID_BD(ID_BD), .ID_valid(ID_valid),
        .delay_slot(delay_slot), .last_PC(last_PC),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    if_id_stage_register #(.RESET_PC(32'h0000_3000), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .IF_PC(IF_PC), .IF_PC4(IF_PC4), .IF_Inst(IF_Inst),
        .IF_exception(IF_exception), .IF_EPC(IF_EPC), .IF_ExcCode(IF_ExcCode), .IF_BD(IF_BD),
        .stall(stall), .handle_exception(handle_exception),
        .ID_PC(s_PC), .ID_PC4(s_PC4), .ID_Inst(s_Inst), .ID_exception(s_exception),
        .ID_EPC(s_EPC), .ID_ExcCode(s_ExcCode), .ID_BD(s_BD), .ID_valid(s_valid),
        .delay_slot(s_delay_slot), .last_PC(s_last_PC),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    typedef struct {
        logic [31:0] pc, pc4, inst, epc;
        logic        exc, bd, valid, ds;
        logic [4:0]  code;
        int unsigned scnt, fcnt;
    } exp_t;

    exp_t        q[$];
    exp_t        m;
    int unsigned total = 0;
    int unsigned passed = 0;

    function automatic logic is_branch(input logic [31:0] inst);
        logic [5:0] op;
        logic [4:0] rt;
        logic [5:0] fn;
        op = inst[31:26];
        rt = inst[20:16];
        fn = inst[5:0];
        return (op inside {6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7}) ||
               (op == 6'd1 && rt inside {5'd0, 5'd1, 5'd16, 5'd17}) ||
               (op == 6'd0 && fn inside {6'd8, 6'd9});
    endfunction

    function automatic int unsigned sat(input int unsigned v, input int unsigned maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input logic rst, input logic st, input logic he, input logic exc,
                        input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] epc,
                        input logic [4:0] code, input logic bd);
        @(negedge clk);
        reset = rst; stall = st; handle_exception = he; IF_exception = exc;
        IF_PC = pc; IF_PC4 = pc + 32'd4; IF_Inst = inst; IF_EPC = epc;
        IF_ExcCode = code; IF_BD = bd;
        if (rst) begin
            m.pc = 32'h3000; m.pc4 = 32'h3004; m.inst = 0; m.epc = 0; m.code = 0;
            m.exc = 0; m.bd = 0; m.valid = 0; m.scnt = 0; m.fcnt = 0;
        end else if (he) begin
            m.pc = pc; m.pc4 = pc + 32'd4; m.inst = 0; m.epc = 0; m.code = 0;
            m.exc = 0; m.bd = 0; m.valid = 0; m.fcnt++;
        end else if (st) begin
            m.scnt++;
        end else begin
            m.pc = pc; m.pc4 = pc + 32'd4; m.inst = exc ? 32'd0 : inst; m.epc = epc;
            m.code = code; m.exc = exc; m.bd = bd; m.valid = 1;
        end
        m.ds = m.valid && !m.exc && is_branch(m.inst);
        q.push_back(m);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 6))
            0: w[31:26] = 6'(4 + $urandom_range(0, 3));
            1: w[31:26] = 6'(2 + $urandom_range(0, 1));
            2: begin w[31:26] = 6'd1; w[20:16] = ($urandom_range(0, 1) != 0) ? 5'd16 : 5'($urandom_range(0, 3)); end
            3: begin w[31:26] = 6'd0; w[5:0] = 6'(8 + $urandom_range(0, 1)); end
            4: begin w[31:26] = 6'd0; w[5:0] = 6'd10; end
            5: w = 32'd0;
            default: ;
        endcase
        return w;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("ID_PC", ID_PC, e.pc);
                check("ID_PC4", ID_PC4, e.pc4);
                check("ID_Inst", ID_Inst, e.inst);
                check("ID_exception", 32'(ID_exception), 32'(e.exc));
                check("ID_EPC", ID_EPC, e.epc);
                check("ID_ExcCode", 32'(ID_ExcCode), 32'(e.code));
                check("ID_BD", 32'(ID_BD), 32'(e.bd));
                check("ID_valid", 32'(ID_valid), 32'(e.valid));
                check("delay_slot", 32'(delay_slot), 32'(e.ds));
                check("last_PC", last_PC, e.pc);
                check("stall_count", 32'(stall_count), sat(e.scnt, 16'hFFFF));
                check("flush_count", 32'(flush_count), sat(e.fcnt, 16'hFFFF));
                check("stall_count4", 32'(s_stall_count), sat(e.scnt, 15));
                check("flush_count4", 32'(s_flush_count), sat(e.fcnt, 15));
            end
        end
    end

    initial begin : driver
        int unsigned guard;
        reset = 1; stall = 0; handle_exception = 0; IF_exception = 0;
        IF_PC = 0; IF_PC4 = 4; IF_Inst = 0; IF_EPC = 0; IF_ExcCode = 0; IF_BD = 0;
        step(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
        step(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
        step(0, 0, 0, 0, 32'h3008, 32'h1000_0003, 32'h0, 5'd0, 0);
        step(0, 0, 0, 1, 32'h3011, 32'h1000_0003, 32'h3010, 5'd4, 0);
        step(0, 0, 0, 0, 32'h300C, 32'h0800_0010, 32'h0, 5'd0, 1);
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 0, $urandom, rand_inst(), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 5'($urandom), 1'($urandom));
        step(0, 1, 1, 0, 32'h4000, 32'h1000_0001, 32'h0, 5'd0, 1);
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 127) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
                 {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, rand_inst(),
                 {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 5'($urandom), 1'($urandom));
        step(1, 1, 1, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
        for (int i = 0; i < 20; i++)
            step(0, 1, 0, 0, $urandom, rand_inst(), 32'h0, 5'd0, 0);
        step(0, 0, 0, 0, 32'h5000, 32'h0000_0008, 32'h0, 5'd0, 0);
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (q.size() > 0) begin
            total++;
            $display("FAIL drain: %0d entries left expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
